serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 96 +++++++++
 tb/tb_serial_add_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Control FSM and Mealy carry datapath for the N-bit serial adder.
// Drives the operand shift registers and assembles the sum LSB-first into o_sum.
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_a_bit,
    input  logic         i_b_bit,
    output logic         o_ld,
    output logic         o_shift,
    output logic         o_sum_bit,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_busy,
    output logic         o_done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ADD,
        DONE
    } state_t;

    state_t        state;
    logic          carry;
    logic [CW-1:0] count;
    logic          sum_bit;
    logic          carry_next;

    assign sum_bit    = i_a_bit ^ i_b_bit ^ carry;
    assign carry_next = (i_a_bit & i_b_bit) | (carry & (i_a_bit ^ i_b_bit));
    assign o_sum_bit  = o_shift & sum_bit;

    // Strobes are registered alongside the state so they track it exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            carry   <= 1'b0;
            count   <= '0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_ld    <= 1'b0;
            o_shift <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_ld    <= 1'b0;
            o_shift <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= LOAD;
                        o_ld   <= 1'b1;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    carry   <= 1'b0;
                    count   <= '0;
                    o_sum   <= '0;
                    o_cout  <= 1'b0;
                    state   <= ADD;
                    o_shift <= 1'b1;
                    o_busy  <= 1'b1;
                end
                ADD: begin
                    carry <= carry_next;
                    o_sum <= {sum_bit, o_sum[N-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        state  <= DONE;
                        o_cout <= carry_next;
                        o_done <= 1'b1;
                    end else begin
                        o_shift <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: models the upstream A/B shift registers
// and compares against plain-arithmetic sums for directed and random operands.
module tb_serial_add_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         a_bit;
    logic         b_bit;
    logic         ld;
    logic         shift;
    logic         sum_bit;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;

    int checks;
    int failures;

    serial_add_ctrl #(.N(N)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_a_bit  (a_bit),
        .i_b_bit  (b_bit),
        .o_ld     (ld),
        .o_shift  (shift),
        .o_sum_bit(sum_bit),
        .o_sum    (sum),
        .o_cout   (cout),
        .o_busy   (busy),
        .o_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream operand registers: load, shift right, or clear.
    always @(posedge clk) begin
        if (ld) begin
            a_reg <= op_a;
            b_reg <= op_b;
        end else if (shift) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
        end else begin
            a_reg <= '0;
            b_reg <= '0;
        end
    end

    assign a_bit = a_reg[0];
    assign b_bit = b_reg[0];

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ld"}, 16'(ld), 16'd0);
        checkOutput({tag, "_shift"}, 16'(shift), 16'd0);
        checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
        checkOutput({tag, "_done"}, 16'(done), 16'd0);
        checkOutput({tag, "_sumbit"}, 16'(sum_bit), 16'd0);
    endtask

    // One operation from a start pulse; optional start injection or mid-add reset.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input bit inject_start, input int abort_at);
        logic [N:0] expect_sum;
        op_a       = a;
        op_b       = b;
        expect_sum = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("load_ld", 16'(ld), 16'd1);
        checkOutput("load_busy", 16'(busy), 16'd1);
        checkOutput("load_shift", 16'(shift), 16'd0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            start = (inject_start && i == 3);
            checkOutput($sformatf("add%0d_shift", i), 16'(shift), 16'd1);
            checkOutput($sformatf("add%0d_ld", i), 16'(ld), 16'd0);
            checkOutput($sformatf("add%0d_sumbit", i), 16'(sum_bit), 16'(expect_sum[i]));
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkIdle("abort");
                checkOutput("abort_sum", 16'(sum), 16'd0);
                checkOutput("abort_cout", 16'(cout), 16'd0);
                for (int j = 0; j < N + 2; j++) begin
                    @(negedge clk);
                    checkOutput("abort_nodone", 16'(done), 16'd0);
                end
                return;
            end
        end
        @(negedge clk);
        start = inject_start;
        checkOutput("done_pulse", 16'(done), 16'd1);
        checkOutput("done_shift", 16'(shift), 16'd0);
        checkOutput("done_busy", 16'(busy), 16'd0);
        checkOutput("done_sum", 16'(sum), 16'(expect_sum[N-1:0]));
        checkOutput("done_cout", 16'(cout), 16'(expect_sum[N]));
        @(negedge clk);
        start = 1'b0;
        checkIdle("after_done");
        checkOutput("hold_sum", 16'(sum), 16'(expect_sum[N-1:0]));
        if (inject_start) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                checkIdle("no_queue");
                checkOutput("hold_sum_idle", 16'(sum), 16'(expect_sum[N-1:0]));
                checkOutput("hold_cout_idle", 16'(cout), 16'(expect_sum[N]));
            end
        end
    endtask

    // Cycles until the next done pulse, bounded.
    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 50);
        if (!done) begin
            checks++;
            failures++;
            $error("[TB] FAIL done_timeout observed=%0d expected<50", cycles);
        end
    endtask

    initial begin
        int gap;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N:0]   held_sum;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("reset_sum", 16'(sum), 16'd0);
        checkOutput("reset_cout", 16'(cout), 16'd0);

        applyStimulus(8'h5A, 8'h3C, 1'b0, -1);
        applyStimulus(8'hFF, 8'h01, 1'b0, -1);
        applyStimulus(8'hFF, 8'hFF, 1'b0, -1);
        applyStimulus(8'h00, 8'h00, 1'b0, -1);
        applyStimulus(8'h5A, 8'h3C, 1'b1, -1);
        applyStimulus(8'hA5, 8'h7E, 1'b0, 4);
        applyStimulus(8'h12, 8'h34, 1'b0, -1);

        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, 1'b0, -1);
        end

        // Held start: done every N+3 cycles with the same result each time.
        op_a     = 8'hC3;
        op_b     = 8'h4D;
        held_sum = {1'b0, op_a} + {1'b0, op_b};
        @(negedge clk);
        start = 1'b1;
        waitDone(gap);
        for (int k = 0; k < 3; k++) begin
            waitDone(gap);
            checkOutput("held_interval", 16'(gap), 16'(N + 3));
            checkOutput("held_sum", 16'({cout, sum}), 16'(held_sum));
        end
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        checkIdle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
